// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive-side blocks: frame geometry
// constants and the receive FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_OVERSAMPLE   = 16;
    localparam int UART_SAMPLE_POINT = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchronizer that brings the asynchronous serial line into the
// CLOCK_50 domain. Both flops reset to 1 so that reset looks like an idle line.
//
// Ports:
//   CLOCK_50   in   system clock
//   reset      in   asynchronous, active-low reset
//   rx_serial  in   raw asynchronous serial line
//   rx_s       out  synchronized serial line
module uart_rx_sync (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic rx_serial,
    output logic rx_s
);

    logic rx_meta;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

endmodule

// File: rtl/uart_rx_shifter.sv
// uart_rx_shifter
// Samples the synchronized serial line at mid-bit on the 16x oversample tick,
// deserializes an 8N1 frame LSB-first, checks start/stop bits and presents the
// byte on a valid/ready interface with framing-error and overrun pulses.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   tick16     in   one-cycle pulse at OVERSAMPLE x baud rate
//   rx_serial  in   raw serial line, idles high
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  byte available, held until accepted
//   rx_ready   in   consumer accepts when rx_valid && rx_ready
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: good frame dropped, previous byte unaccepted
//   busy       out  high whenever the FSM is not idle
module uart_rx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int OVERSAMPLE   = UART_OVERSAMPLE,
    parameter int SAMPLE_POINT = UART_SAMPLE_POINT
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 tick16,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

    uart_rx_state_t       state, state_next;
    logic [CNT_W-1:0]     sample_cnt, cnt_next;
    logic [IDX_W-1:0]     bit_idx, idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 load_byte;
    logic                 ferr_next;
    logic                 ovr_next;
    logic                 rx_s;

    uart_rx_sync u_sync (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .rx_serial (rx_serial),
        .rx_s      (rx_s)
    );

    assign busy = (state != IDLE);

    // State, counters and the output register. The handshake runs every
    // cycle; a load in the same cycle as an accept wins and keeps rx_valid up.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            sample_cnt <= cnt_next;
            bit_idx    <= idx_next;
            shreg      <= shreg_next;
            frame_err  <= ferr_next;
            overrun    <= ovr_next;
            if (load_byte) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Next-state logic. Nothing moves unless tick16 is high. The stop bit is
    // judged at mid-bit and the FSM returns to IDLE right away, half a bit
    // early, so it can resync on the very next start edge.
    always_comb begin
        state_next = state;
        cnt_next   = sample_cnt;
        idx_next   = bit_idx;
        shreg_next = shreg;
        load_byte  = 1'b0;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;

        if (tick16) begin
            if (state != IDLE) begin
                cnt_next = (sample_cnt == LAST_TICK) ? '0 : sample_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end

                START: begin
                    // A line back high at mid start bit was only a glitch.
                    if (sample_cnt == SAMPLE_AT && rx_s) begin
                        state_next = IDLE;
                    end else if (sample_cnt == LAST_TICK) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end
                end

                DATA: begin
                    if (sample_cnt == SAMPLE_AT) begin
                        shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
                    end
                    if (sample_cnt == LAST_TICK) begin
                        if (bit_idx == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            idx_next = bit_idx + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (sample_cnt == SAMPLE_AT) begin
                        if (rx_s) begin
                            state_next = IDLE;
                            if (!rx_valid || rx_ready) begin
                                load_byte = 1'b1;
                            end else begin
                                ovr_next = 1'b1;
                            end
                        end else begin
                            state_next = BREAK;
                            ferr_next  = 1'b1;
                        end
                    end
                end

                BREAK: begin
                    // Wait for the line to go high so a held-low line
                    // cannot start a new frame.
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
